pixel_sum_sequencer: RTL and testbench

- Front-end driver and result collector for the 8-lane pixel accumulator (pixel_parallel_sum).
- Accepts a byte-wide pixel stream and packs 8 pixels per 64-bit word.
- Drives the accumulator's data/CE/LOAD/ADDSUB controls, one window at a time.
- Captures the 25-bit window total and hands it downstream on a valid/ready interface, together with the pixel count.

---
 rtl/pixel_sum_sequencer.sv | 151 +++++++++++++++
 tb/tb_pixel_sum_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_sum_sequencer.sv
// Packs a byte-wide pixel stream into 64-bit words, drives the 8-lane pixel
// accumulator one window at a time and returns each window total downstream.
module pixel_sum_sequencer #(
    parameter int WORDS_PER_WINDOW = 16,
    parameter int CNT_W            = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    input  logic             pix_last,
    output logic             pix_ready,
    output logic [63:0]      sum_data,
    output logic             sum_ce,
    output logic             sum_load,
    output logic             sum_addsub,
    input  logic [24:0]      total_sum_in,
    output logic [24:0]      result_sum,
    output logic [CNT_W-1:0] result_count,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int                WCNT_W     = $clog2(WORDS_PER_WINDOW + 1);
    localparam logic [WCNT_W-1:0] WORDS_LAST = WCNT_W'(WORDS_PER_WINDOW);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_PACK  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t            state_r;
    logic [63:0]       pack_r;
    logic [2:0]        byte_idx_r;
    logic [WCNT_W-1:0] word_cnt_r;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic              last_seen_r;

    logic [63:0]       pack_merged_s;
    logic [WCNT_W-1:0] word_cnt_inc_s;

    // Pack register with the incoming pixel dropped into the current byte lane.
    always_comb begin
        pack_merged_s = pack_r;
        pack_merged_s[{byte_idx_r, 3'b000} +: 8] = pix_in;
        word_cnt_inc_s = word_cnt_r + WCNT_W'(1);
    end

    // Window sequencing FSM; every output is registered alongside the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= S_CLEAR;
            pack_r       <= 64'd0;
            byte_idx_r   <= 3'd0;
            word_cnt_r   <= '0;
            pix_cnt_r    <= '0;
            last_seen_r  <= 1'b0;
            pix_ready    <= 1'b0;
            sum_data     <= 64'd0;
            sum_ce       <= 1'b0;
            sum_load     <= 1'b0;
            sum_addsub   <= 1'b1;
            result_sum   <= 25'd0;
            result_count <= '0;
            result_valid <= 1'b0;
        end else begin
            sum_addsub <= 1'b1;
            case (state_r)
                S_CLEAR: begin
                    pack_r      <= 64'd0;
                    byte_idx_r  <= 3'd0;
                    word_cnt_r  <= '0;
                    pix_cnt_r   <= '0;
                    last_seen_r <= 1'b0;
                    // Arriving from OUT the clear pulse is already on the pins;
                    // straight out of reset it still has to be raised once.
                    if (sum_load) begin
                        sum_ce    <= 1'b0;
                        sum_load  <= 1'b0;
                        pix_ready <= 1'b1;
                        state_r   <= S_PACK;
                    end else begin
                        sum_ce   <= 1'b1;
                        sum_load <= 1'b1;
                    end
                end
                S_PACK: begin
                    if (pix_valid) begin
                        pack_r     <= pack_merged_s;
                        byte_idx_r <= byte_idx_r + 3'd1;
                        pix_cnt_r  <= pix_cnt_r + CNT_W'(1);
                        if ((byte_idx_r == 3'd7) || pix_last) begin
                            last_seen_r <= pix_last;
                            pix_ready   <= 1'b0;
                            sum_ce      <= 1'b1;
                            sum_load    <= 1'b0;
                            sum_data    <= pack_merged_s;
                            state_r     <= S_ISSUE;
                        end else begin
                            state_r <= S_PACK;
                        end
                    end else begin
                        state_r <= S_PACK;
                    end
                end
                S_ISSUE: begin
                    word_cnt_r <= word_cnt_inc_s;
                    sum_ce     <= 1'b0;
                    sum_data   <= 64'd0;
                    if ((word_cnt_inc_s == WORDS_LAST) || last_seen_r) begin
                        state_r <= S_WAIT;
                    end else begin
                        pack_r     <= 64'd0;
                        byte_idx_r <= 3'd0;
                        pix_ready  <= 1'b1;
                        state_r    <= S_PACK;
                    end
                end
                S_WAIT: begin
                    // Accumulator output settled during this cycle.
                    result_sum   <= total_sum_in;
                    result_count <= pix_cnt_r;
                    result_valid <= 1'b1;
                    state_r      <= S_OUT;
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        sum_ce       <= 1'b1;
                        sum_load     <= 1'b1;
                        state_r      <= S_CLEAR;
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                default: begin
                    pix_ready    <= 1'b0;
                    sum_ce       <= 1'b0;
                    sum_load     <= 1'b0;
                    sum_data     <= 64'd0;
                    result_valid <= 1'b0;
                    state_r      <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sum_sequencer.sv
// Directed bench for pixel_sum_sequencer with a behavioural 8-lane accumulator
// standing in for pixel_parallel_sum.
module tb_pixel_sum_sequencer;

    localparam int WPW   = 2;
    localparam int CNT_W = 18;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [7:0]       pix_in = 8'd0;
    logic             pix_valid = 1'b0;
    logic             pix_last = 1'b0;
    logic             pix_ready;
    logic [63:0]      sum_data;
    logic             sum_ce;
    logic             sum_load;
    logic             sum_addsub;
    logic [24:0]      total_sum_in;
    logic [24:0]      result_sum;
    logic [CNT_W-1:0] result_count;
    logic             result_valid;
    logic             result_ready = 1'b0;

    pixel_sum_sequencer #(.WORDS_PER_WINDOW(WPW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
        .sum_data(sum_data), .sum_ce(sum_ce), .sum_load(sum_load), .sum_addsub(sum_addsub),
        .total_sum_in(total_sum_in),
        .result_sum(result_sum), .result_count(result_count),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 CLK = ~CLK;

    // Accumulator stand-in: clear on CE+LOAD, add all eight lanes on CE.
    logic [24:0] acc_r;
    function automatic logic [24:0] lane_sum(input logic [63:0] w);
        logic [24:0] s;
        s = 25'd0;
        for (int i = 0; i < 8; i++) s = s + {17'd0, w[i*8 +: 8]};
        return s;
    endfunction
    always @(posedge CLK or posedge RST) begin
        if (RST) acc_r <= 25'd0;
        else if (sum_ce && sum_load) acc_r <= 25'd0;
        else if (sum_ce) acc_r <= acc_r + lane_sum(sum_data);
    end
    assign total_sum_in = acc_r;

    // Issued words and result_valid rising edges, sampled mid-cycle.
    logic [63:0] word_q[$];
    int   rv_pulses = 0;
    logic rv_prev = 1'b0;
    always @(negedge CLK) begin
        if (sum_ce && !sum_load) word_q.push_back(sum_data);
        if (result_valid && !rv_prev) rv_pulses++;
        rv_prev = result_valid;
    end

    int checks = 0;
    int passes = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_pix(input logic [7:0] v, input logic last);
        int n;
        n = 0;
        while (!pix_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!pix_ready) check_val("pix_ready_timeout", {63'd0, pix_ready}, 64'd1);
        pix_valid = 1'b1;
        pix_in    = v;
        pix_last  = last;
        @(negedge CLK);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!result_valid) check_val({tag, "_timeout"}, {63'd0, result_valid}, 64'd1);
    endtask

    task automatic take_result(input string tag, input logic [24:0] exp_sum, input logic [CNT_W-1:0] exp_cnt);
        wait_result(tag);
        check_val({tag, "_sum"}, {39'd0, result_sum}, {39'd0, exp_sum});
        check_val({tag, "_count"}, {46'd0, result_count}, {46'd0, exp_cnt});
        result_ready = 1'b1;
        @(negedge CLK);
        result_ready = 1'b0;
    endtask

    initial begin
        int snap;

        // Reset and CLEAR
        repeat (3) begin
            @(negedge CLK);
            check_val("rst_ctl", {58'd0, sum_ce, sum_load, pix_ready, result_valid, sum_addsub, 1'b0}, 64'h2);
            check_val("rst_data", sum_data, 64'd0);
            check_val("rst_result", {21'd0, result_sum, result_count}, 64'd0);
        end
        RST = 1'b0;
        @(negedge CLK);
        check_val("clear_pulse", {61'd0, sum_ce, sum_load, pix_ready}, 64'h6);
        @(negedge CLK);
        check_val("pack_entry", {61'd0, sum_ce, sum_load, pix_ready}, 64'h1);

        // Full window of 0xFF
        word_q.delete();
        for (int i = 0; i < 16; i++) send_pix(8'hFF, 1'b0);
        take_result("full", 25'd4080, 18'd16);
        check_val("full_issues", 64'(word_q.size()), 64'd2);
        foreach (word_q[i]) check_val("full_word", word_q[i], 64'hFFFF_FFFF_FFFF_FFFF);

        // Byte-lane order, last on lane 7
        word_q.delete();
        for (int i = 1; i <= 8; i++) send_pix(8'(i), i == 8);
        take_result("order", 25'd36, 18'd8);
        check_val("order_issues", 64'(word_q.size()), 64'd1);
        foreach (word_q[i]) check_val("order_word", word_q[i], 64'h0807060504030201);

        // Early last
        word_q.delete();
        send_pix(8'd10, 1'b0);
        send_pix(8'd20, 1'b0);
        send_pix(8'd30, 1'b1);
        take_result("early", 25'd60, 18'd3);
        check_val("early_issues", 64'(word_q.size()), 64'd1);
        foreach (word_q[i]) check_val("early_word", word_q[i], 64'h0000_0000_001E_140A);

        // Single-pixel window
        word_q.delete();
        send_pix(8'h55, 1'b1);
        take_result("single", 25'd85, 18'd1);
        check_val("single_issues", 64'(word_q.size()), 64'd1);
        foreach (word_q[i]) check_val("single_word", word_q[i], 64'h55);

        // Back-pressure in OUT
        for (int i = 0; i < 8; i++) send_pix(8'd3, i == 7);
        wait_result("bp");
        word_q.delete();
        pix_valid = 1'b1;
        pix_in    = 8'hAA;
        repeat (5) begin
            @(negedge CLK);
            check_val("bp_hold", {60'd0, result_valid, pix_ready, sum_ce, sum_load}, 64'h8);
            check_val("bp_sum", {39'd0, result_sum}, 64'd24);
        end
        check_val("bp_count", {46'd0, result_count}, 64'd8);
        check_val("bp_no_issue", 64'(word_q.size()), 64'd0);
        result_ready = 1'b1;
        @(negedge CLK);
        result_ready = 1'b0;
        pix_valid    = 1'b0;
        check_val("bp_clear", {61'd0, result_valid, sum_ce, sum_load}, 64'h3);
        send_pix(8'd5, 1'b0);
        send_pix(8'd5, 1'b0);
        send_pix(8'd5, 1'b1);
        take_result("bp_next", 25'd15, 18'd3);

        // Reset mid-window
        for (int i = 0; i < 5; i++) send_pix(8'd7, 1'b0);
        snap = rv_pulses;
        RST = 1'b1;
        #1;
        check_val("midrst_out", {61'd0, pix_ready, sum_ce, result_valid}, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check_val("midrst_no_result", 64'(rv_pulses), 64'(snap));
        for (int i = 0; i < 8; i++) send_pix(8'd2, i == 7);
        take_result("midrst_fresh", 25'd16, 18'd8);
        check_val("midrst_pulses", 64'(rv_pulses), 64'(snap + 1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
